recorder_mem_ctrl: RTL and testbench

- Sequences the single-port sample BRAM behind the lab 5 voice recorder.
- Record mode writes AC97 input samples into the BRAM. Playback mode reads them back and loops.
- Optional DECIM:1 rate reduction applies when `filter` is set: store every DECIM-th sample, hold each played sample for DECIM strobes.
- Sits between the AC97 sample interface (`ready` strobe, 48 kHz) and the BRAM. The FIR datapath, if present, sits upstream on `from_ac97_data`.

---
 rtl/recorder_pkg.sv | 22 ++
 rtl/sample_rate_div.sv | 41 ++++
 rtl/recorder_mem_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_recorder_mem_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/recorder_pkg.sv
// recorder_pkg
//   Shared definitions for the voice-recorder BRAM sequencer:
//   - FSM state encoding
//   - record/play mode constants
//   - default geometry (address width, sample width, decimation factor)
package recorder_pkg;

    localparam int AW_DEF    = 16;
    localparam int DW_DEF    = 8;
    localparam int DECIM_DEF = 8;

    localparam logic MODE_RECORD = 1'b0;
    localparam logic MODE_PLAY   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WRITE   = 2'd1,
        S_READ    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

endpackage

// File: rtl/sample_rate_div.sv
// sample_rate_div
//   Modulo-DECIM strobe counter used for DECIM:1 rate reduction.
//   Ports:
//     clock, reset : system clock, synchronous active-high reset
//     clear        : synchronous clear of the count
//     en           : advance the count by one (mod DECIM)
//     tick         : high while count == 0
//   When clear and en are both high, the strobe that caused the clear is
//   counted from zero, so the count lands on 1.
module sample_rate_div #(
    parameter int DECIM = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] base;

    always_comb begin
        base = clear ? '0 : count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= (base == CW'(DECIM - 1)) ? '0 : base + CW'(1);
        end else if (clear) begin
            count_q <= '0;
        end
    end

    assign tick = (count_q == '0);

endmodule

// File: rtl/recorder_mem_ctrl.sv
// recorder_mem_ctrl
//   Sequences the single-port sample BRAM of the voice recorder. Record
//   mode writes incoming AC97 samples, playback mode reads them back in a
//   continuous loop. With rate reduction enabled for a recording, only every
//   DECIM-th sample is stored and each stored sample is held for DECIM
//   strobes on playback.
//   Ports:
//     clock, reset   : system clock, synchronous active-high reset
//     ready          : one-cycle sample strobe from the AC97 interface
//     playback       : 1 = play, 0 = record (sampled with ready)
//     filter         : rate-reduction enable (sampled with ready)
//     from_ac97_data : input sample, valid with ready
//     to_ac97_data   : playback sample (registered, held between updates)
//     mem_addr/mem_we/mem_din : registered BRAM controls
//     mem_dout       : BRAM read data, one-cycle latency
//     rec_len        : samples stored in the last/current recording
//     full           : write pointer reached 2^AW
//   Strobe protocol: ready is a pure valid with no back-pressure. It is
//   accepted only when the FSM is in S_IDLE; a strobe arriving while a
//   previous one is still being serviced is dropped. Servicing takes at most
//   four cycles, far below the sample period.
module recorder_mem_ctrl
    import recorder_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int DECIM = DECIM_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ready,
    input  logic          playback,
    input  logic          filter,
    input  logic [DW-1:0] from_ac97_data,
    output logic [DW-1:0] to_ac97_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic [AW:0]   rec_len,
    output logic          full
);

    state_t state_q, state_d;

    logic          mode_q;
    logic          rec_filt_q;
    logic          first_pend_q;   // no strobe accepted since reset
    logic          zero_pend_q;    // empty-recording playback: clear output next edge
    logic          cap_wait_q;     // second cycle of S_CAPTURE (BRAM data valid)
    logic [AW:0]   wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   end_len_q;
    logic [DW-1:0] sample_q;
    logic          full_q;

    // Strobe decode
    logic          accept;
    logic          to_play;
    logic          to_rec;
    logic          filt_eff;
    logic          full_eff;
    logic [AW:0]   end_len_eff;
    logic          tick;
    logic          tick_eff;
    logic          cnt_clear;
    logic          cnt_en;
    logic          write_go;
    logic          read_go;
    logic          zero_play;

    // Next values of the registered outputs
    logic [DW-1:0] to_ac97_d;
    logic [AW-1:0] mem_addr_d;
    logic          mem_we_d;
    logic [DW-1:0] mem_din_d;

    sample_rate_div #(.DECIM(DECIM)) u_rate_div (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .en    (cnt_en),
        .tick  (tick)
    );

    // Everything is decided on the accepting edge, using the values the
    // mode change is about to establish (cleared counter, new rec_filt,
    // captured end_len, cleared full).
    always_comb begin
        accept      = (state_q == S_IDLE) && ready;
        to_play     = accept && (playback == MODE_PLAY)   && (mode_q == MODE_RECORD);
        to_rec      = accept && (playback == MODE_RECORD) && (mode_q == MODE_PLAY);
        filt_eff    = (first_pend_q || to_rec) ? filter : rec_filt_q;
        full_eff    = to_rec ? 1'b0 : full_q;
        end_len_eff = to_play ? wr_ptr_q : end_len_q;
        cnt_clear   = to_play || to_rec;
        tick_eff    = cnt_clear || tick;
        cnt_en      = accept && filt_eff;
        write_go    = accept && (playback == MODE_RECORD) && !full_eff
                      && !(filt_eff && !tick_eff);
        zero_play   = accept && (playback == MODE_PLAY) && (end_len_eff == '0);
        read_go     = accept && (playback == MODE_PLAY) && (end_len_eff != '0)
                      && !(filt_eff && !tick_eff);
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (write_go) begin
                    state_d = S_WRITE;
                end else if (read_go) begin
                    state_d = S_READ;
                end
            end
            S_WRITE:   state_d = S_IDLE;
            S_READ:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = cap_wait_q ? S_IDLE : S_CAPTURE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM: outputs (next values of the registered BRAM/sample outputs).
    // mem_we defaults low so every write is a single-cycle pulse.
    always_comb begin
        to_ac97_d  = to_ac97_data;
        mem_addr_d = mem_addr;
        mem_we_d   = 1'b0;
        mem_din_d  = mem_din;
        if (zero_pend_q) begin
            to_ac97_d = '0;
        end
        case (state_q)
            S_WRITE: begin
                mem_addr_d = wr_ptr_q[AW-1:0];
                mem_din_d  = sample_q;
                mem_we_d   = 1'b1;
            end
            S_READ: begin
                mem_addr_d = rd_ptr_q;
            end
            S_CAPTURE: begin
                if (cap_wait_q) begin
                    to_ac97_d = mem_dout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            to_ac97_data <= '0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_din      <= '0;
            mode_q       <= MODE_RECORD;
            rec_filt_q   <= 1'b0;
            first_pend_q <= 1'b1;
            zero_pend_q  <= 1'b0;
            cap_wait_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            end_len_q    <= '0;
            sample_q     <= '0;
            full_q       <= 1'b0;
        end else begin
            to_ac97_data <= to_ac97_d;
            mem_addr     <= mem_addr_d;
            mem_we       <= mem_we_d;
            mem_din      <= mem_din_d;
            zero_pend_q  <= zero_play;

            if (accept) begin
                mode_q       <= playback;
                first_pend_q <= 1'b0;
                sample_q     <= from_ac97_data;
                if (first_pend_q || to_rec) begin
                    rec_filt_q <= filter;
                end
            end
            if (to_play) begin
                end_len_q <= wr_ptr_q;
                rd_ptr_q  <= '0;
            end
            if (to_rec) begin
                wr_ptr_q <= '0;
                full_q   <= 1'b0;
            end

            case (state_q)
                S_WRITE: begin
                    wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
                    // Last address written: pointer is about to reach 2^AW.
                    full_q   <= (wr_ptr_q[AW-1:0] == '1);
                end
                S_READ: begin
                    // Loop back to the start after the last stored sample.
                    if (({1'b0, rd_ptr_q} + (AW+1)'(1)) == end_len_q) begin
                        rd_ptr_q <= '0;
                    end else begin
                        rd_ptr_q <= rd_ptr_q + AW'(1);
                    end
                end
                S_CAPTURE: cap_wait_q <= !cap_wait_q;
                default: ;
            endcase
        end
    end

    assign rec_len = wr_ptr_q;
    assign full    = full_q;

endmodule

// File: tb/tb_recorder_mem_ctrl.sv
// tb_recorder_mem_ctrl
//   Directed bench for recorder_mem_ctrl with AW=4, DW=8, DECIM=4 and a
//   sample strobe every 20 clocks. A behavioural BRAM with one-cycle read
//   latency sits on the memory port. Stimulus tasks push the expected BRAM
//   writes and expected playback samples (with the edge they must appear
//   on) into queues; a negedge monitor pops and compares them.
module tb_recorder_mem_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DECIM = 4;
    localparam int GAP   = 20;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ready = 1'b0;
    logic          playback = 1'b0;
    logic          filter = 1'b0;
    logic [DW-1:0] from_ac97_data = '0;
    logic [DW-1:0] to_ac97_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic [AW:0]   rec_len;
    logic          full;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected BRAM writes {addr, din} and the edge index they appear after
    logic [AW+DW-1:0] expw_q[$];
    int               expw_t[$];
    // Expected playback sample, the value just before it, and its edge index
    logic [DW-1:0]    expp_q[$];
    logic [DW-1:0]    expp_prev[$];
    int               expp_t[$];
    logic [DW-1:0]    last_play = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    recorder_mem_ctrl #(.AW(AW), .DW(DW), .DECIM(DECIM)) dut (
        .clock          (clock),
        .reset          (reset),
        .ready          (ready),
        .playback       (playback),
        .filter         (filter),
        .from_ac97_data (from_ac97_data),
        .to_ac97_data   (to_ac97_data),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .rec_len        (rec_len),
        .full           (full)
    );

    // ---------------- clock / reset / BRAM ----------------
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    end

    always @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Issue one ready strobe; e0 is the index of the edge that samples it.
    task automatic strobe(input logic pb, input logic flt, input logic [DW-1:0] d, output int e0);
        repeat (GAP - 1) @(posedge clock);
        #1;
        playback = pb;
        filter = flt;
        from_ac97_data = d;
        ready = 1'b1;
        @(posedge clock);
        #1;
        ready = 1'b0;
        e0 = cyc;
    endtask

    task automatic rec(input logic [DW-1:0] d, input logic flt, input logic wr, input int addr);
        int e0;
        strobe(1'b0, flt, d, e0);
        if (wr) begin
            expw_q.push_back({addr[AW-1:0], d});
            expw_t.push_back(e0 + 1);
        end
    endtask

    task automatic play(input logic flt, input logic [DW-1:0] val, input int lat);
        int e0;
        strobe(1'b1, flt, 8'h00, e0);
        expp_q.push_back(val);
        expp_prev.push_back(last_play);
        expp_t.push_back(e0 + lat);
        last_play = val;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (mem_we) begin
            checks++;
            if (expw_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected addr=0x%0h din=0x%0h cyc=%0d", mem_addr, mem_din, cyc);
            end else begin
                logic [AW+DW-1:0] w;
                int t;
                w = expw_q.pop_front();
                t = expw_t.pop_front();
                if ({mem_addr, mem_din} !== w || cyc != t) begin
                    errors++;
                    $display("FAIL write addr/din=0x%0h/0x%0h cyc=%0d expected 0x%0h/0x%0h cyc=%0d",
                             mem_addr, mem_din, cyc, w[AW+DW-1:DW], w[DW-1:0], t);
                end
            end
        end else if (expw_t.size() > 0 && cyc >= expw_t[0]) begin
            logic [AW+DW-1:0] w;
            int t;
            w = expw_q.pop_front();
            t = expw_t.pop_front();
            checks++;
            errors++;
            $display("FAIL write_missing actual=none expected addr=0x%0h din=0x%0h cyc=%0d",
                     w[AW+DW-1:DW], w[DW-1:0], t);
        end

        if (expp_t.size() > 0) begin
            if (cyc == expp_t[0] - 1) begin
                checks++;
                if (to_ac97_data !== expp_prev[0]) begin
                    errors++;
                    $display("FAIL play_early actual=0x%0h expected=0x%0h cyc=%0d",
                             to_ac97_data, expp_prev[0], cyc);
                end
            end else if (cyc >= expp_t[0]) begin
                logic [DW-1:0] v;
                v = expp_q.pop_front();
                void'(expp_prev.pop_front());
                void'(expp_t.pop_front());
                checks++;
                if (to_ac97_data !== v) begin
                    errors++;
                    $display("FAIL play_sample actual=0x%0h expected=0x%0h cyc=%0d",
                             to_ac97_data, v, cyc);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [DW-1:0] filt_vals [0:2];
        int e0;
        filt_vals[0] = 8'h20;
        filt_vals[1] = 8'h24;
        filt_vals[2] = 8'h28;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_outputs", 32'({to_ac97_data, mem_addr, mem_we, mem_din, rec_len, full}), 32'd0);

        // Record six samples, no rate reduction
        for (int i = 0; i < 6; i++) rec(8'h10 + 8'(i), 1'b0, 1'b1, i);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rec_len_6", 32'(rec_len), 32'd6);
        check("not_full_6", 32'(full), 32'd0);

        // Play 14 strobes: loops over the six samples
        for (int i = 0; i < 14; i++) play(1'b0, 8'h10 + 8'(i % 6), 3);

        // Record 20 samples: only 16 fit
        for (int i = 0; i < 20; i++) begin
            rec(8'h40 + 8'(i), 1'b0, i < 16, i);
            if (i == 14 || i == 15) begin
                repeat (3) @(posedge clock);
                @(negedge clock);
                check(i == 14 ? "full_after_15" : "full_after_16", 32'(full), (i == 15) ? 32'd1 : 32'd0);
            end
        end
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rec_len_16", 32'(rec_len), 32'd16);
        check("full_16", 32'(full), 32'd1);
        play(1'b0, 8'h40, 3);
        play(1'b0, 8'h41, 3);

        // Rate-reduced recording: every 4th sample stored
        for (int i = 0; i < 12; i++) rec(8'h20 + 8'(i), 1'b1, (i % 4) == 0, i / 4);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rec_len_filt", 32'(rec_len), 32'd3);
        check("full_cleared", 32'(full), 32'd0);
        // Playback with filter low: rate follows the recording
        for (int i = 0; i < 14; i++) play(1'b0, filt_vals[(i / 4) % 3], 3);

        // Reset one cycle after an accepted record strobe aborts the write
        rec(8'h55, 1'b0, 1'b1, 0);
        strobe(1'b0, 1'b0, 8'h66, e0);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        last_play = '0;
        @(negedge clock);
        check("abort_outputs", 32'({to_ac97_data, mem_addr, mem_we, mem_din, rec_len, full}), 32'd0);
        rec(8'h77, 1'b0, 1'b1, 0);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("rec_len_after_abort", 32'(rec_len), 32'd1);

        // Playback straight after reset with nothing recorded
        repeat (10) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        last_play = '0;
        for (int i = 0; i < 3; i++) play(1'b0, 8'h00, 1);
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("empty_play_rec_len", 32'(rec_len), 32'd0);

        repeat (10) @(posedge clock);
        @(negedge clock);
        check("writes_drained", 32'(expw_q.size()), 32'd0);
        check("plays_drained", 32'(expp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound on total run time
    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
